// File: rtl/button_event_ctrl.sv
// Push-button controller: sync, debounce, press capture (W1C), maskable irq, 4-word Avalon-MM slave.
// Optional auto-repeat of held keys is compiled in with `define BUTTON_EVENT_CTRL_AUTOREPEAT_EN.
module button_event_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int ACTIVE_LOW      = 1,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] RELEASED = (ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
    $error("button_event_ctrl: parameter out of range");
  end

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] pressed_raw_s, rise_s, press_s, repeat_s, repen_s, w1c_s;
  logic             wr_s;
  logic             unused_s;

  assign pressed_raw_s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign wr_s          = chipselect & ~write_n;
  assign unused_s      = ^writedata;

  // Per-bit debounce: a level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    rise_s   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = {CW{1'b0}};
      if (pressed_raw_s[i] == stable_q[i]) begin
        cnt_d[i] = {CW{1'b0}};
      end else if (cnt_q[i] == CNT_MAX) begin
        stable_d[i] = ~stable_q[i];
        rise_s[i]   = ~stable_q[i];
        cnt_d[i]    = {CW{1'b0}};
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

`ifdef BUTTON_EVENT_CTRL_AUTOREPEAT_EN
  localparam int HMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW   = $clog2(HMAX + 1);
  localparam logic [HW-1:0] DELAY_END  = HW'(REPEAT_DELAY - 1);
  localparam logic [HW-1:0] PERIOD_END = HW'(REPEAT_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_ONE   = HW'(1);

  logic [HW-1:0]    hold_q [WIDTH];
  logic [HW-1:0]    hold_d [WIDTH];
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] repen_q, repen_d;

  assign repen_s = repen_q;

  // Hold timers: first repeat after REPEAT_DELAY held cycles, then one every REPEAT_PERIOD.
  always_comb begin
    repeat_s = {WIDTH{1'b0}};
    phase_d  = phase_q;
    for (int i = 0; i < WIDTH; i++) begin
      hold_d[i] = hold_q[i];
      if (!stable_q[i] || !repen_q[i]) begin
        hold_d[i]  = {HW{1'b0}};
        phase_d[i] = 1'b0;
      end else if (hold_q[i] == (phase_q[i] ? PERIOD_END : DELAY_END)) begin
        repeat_s[i] = 1'b1;
        hold_d[i]   = {HW{1'b0}};
        phase_d[i]  = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + HOLD_ONE;
      end
    end
    if (wr_s && address == 2'd1) begin
      repen_d = writedata[WIDTH-1:0];
    end else begin
      repen_d = repen_q;
    end
  end

  // Auto-repeat state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= {WIDTH{1'b0}};
      repen_q <= {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= {HW{1'b0}};
    end else begin
      phase_q <= phase_d;
      repen_q <= repen_d;
      for (int i = 0; i < WIDTH; i++) hold_q[i] <= hold_d[i];
    end
  end
`else
  assign repen_s  = {WIDTH{1'b0}};
  assign repeat_s = {WIDTH{1'b0}};
`endif

  assign press_s = rise_s | repeat_s;

  // Register-file next state; a press wins over a same-cycle clear so no event is lost.
  always_comb begin
    if (wr_s && address == 2'd3) begin
      w1c_s = writedata[WIDTH-1:0];
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end
    if (wr_s && address == 2'd2) begin
      irqmask_d = writedata[WIDTH-1:0];
    end else begin
      irqmask_d = irqmask_q;
    end
    edgecap_d = press_s | (edgecap_q & ~w1c_s);
    irq_d     = |(edgecap_q & irqmask_q);
    case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd1:    readdata_d = 32'(repen_s);
      2'd2:    readdata_d = 32'(irqmask_q);
      2'd3:    readdata_d = 32'(edgecap_q);
      default: readdata_d = 32'd0;
    endcase
  end

  // Main state; synchroniser resets to the released level so reset release never looks like a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= RELEASED;
      sync2_q    <= RELEASED;
      stable_q   <= {WIDTH{1'b0}};
      edgecap_q  <= {WIDTH{1'b0}};
      irqmask_q  <= {WIDTH{1'b0}};
      readdata_q <= 32'd0;
      irq_q      <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= {CW{1'b0}};
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      edgecap_q  <= edgecap_d;
      irqmask_q  <= irqmask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
